// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - shared memory port between the multicycle controller and memory
interface multicycle_ctrl_if;
  logic mem_req;
  logic MemRW;
  logic mem_ready;

  modport master (output mem_req, output MemRW, input mem_ready);
  modport slave  (input mem_req, input MemRW, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - RV32I multicycle sequencer: FETCH/DECODE/EXEC/MEM/WB over one memory port
module multicycle_ctrl #(
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_WIDTH    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_ctrl_if.master    mem,
  input  logic [4:0]           opcode_eff,
  input  logic [2:0]           funct3,
  input  logic                 BrEq,
  input  logic                 BrLT,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 PCSel,
  output logic [2:0]           ImmSel,
  output logic                 RegWEn,
  output logic                 BrUn,
  output logic                 ASel,
  output logic                 BSel,
  output logic [1:0]           WBSel,
  output logic                 arithmetic,
  output logic                 i_type,
  output logic                 retire,
  output logic [CNT_WIDTH-1:0] instret,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_OPIMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_AUIPC, C_LUI, C_ILLEGAL
  } op_class_t;

  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(MEM_TIMEOUT - 1);

  state_t               state, state_d;
  op_class_t            cls;
  logic [TO_WIDTH-1:0]  to_cnt;
  logic                 mem_req_c, memrw_c, irwrite_c, pcwrite_c, pcsel_c, regwen_c, retire_c;
  logic                 trap_set;
  logic [1:0]           cause_d;
  logic                 limit_hit;
  logic                 taken;
  logic                 fields_en;
  logic [2:0]           imm_c;
  logic [1:0]           wb_c;
  logic                 brun_c, asel_c, bsel_c, arith_c, itype_c;

  always_comb begin
    cls = C_ILLEGAL;
    case (opcode_eff)
      5'b01100: cls = C_R;
      5'b00100: cls = C_OPIMM;
      5'b00000: cls = C_LOAD;
      5'b01000: cls = C_STORE;
      5'b11000: cls = C_BRANCH;
      5'b11011: cls = C_JAL;
      5'b11001: cls = C_JALR;
      5'b00101: cls = C_AUIPC;
      5'b01101: cls = C_LUI;
      default:  cls = C_ILLEGAL;
    endcase
  end

  always_comb begin
    imm_c   = 3'd0;
    wb_c    = 2'd0;
    brun_c  = 1'b0;
    asel_c  = 1'b0;
    bsel_c  = 1'b0;
    arith_c = 1'b0;
    itype_c = 1'b0;
    case (cls)
      C_R:      begin wb_c = 2'd1; arith_c = 1'b1; end
      C_OPIMM:  begin imm_c = 3'd0; bsel_c = 1'b1; wb_c = 2'd1; arith_c = 1'b1; itype_c = 1'b1; end
      C_LOAD:   begin imm_c = 3'd0; bsel_c = 1'b1; wb_c = 2'd0; itype_c = 1'b1; end
      C_STORE:  begin imm_c = 3'd1; bsel_c = 1'b1; end
      C_BRANCH: begin imm_c = 3'd2; asel_c = 1'b1; bsel_c = 1'b1; brun_c = funct3[1]; end
      C_JAL:    begin imm_c = 3'd3; asel_c = 1'b1; bsel_c = 1'b1; wb_c = 2'd2; end
      C_JALR:   begin imm_c = 3'd0; bsel_c = 1'b1; wb_c = 2'd2; itype_c = 1'b1; end
      C_AUIPC:  begin imm_c = 3'd4; asel_c = 1'b1; bsel_c = 1'b1; wb_c = 2'd1; end
      C_LUI:    begin imm_c = 3'd4; wb_c = 2'd3; end
      default:  ;
    endcase
  end

  assign taken     = funct3[2] ? (BrLT ^ funct3[0]) : (BrEq ^ funct3[0]);
  // A ready arriving on the limit cycle completes the access instead of trapping.
  assign limit_hit = (MEM_TIMEOUT != 0) && (to_cnt == TO_LIMIT) && !mem.mem_ready;

  always_comb begin
    state_d   = state;
    mem_req_c = 1'b0;
    memrw_c   = 1'b0;
    irwrite_c = 1'b0;
    pcwrite_c = 1'b0;
    pcsel_c   = 1'b0;
    regwen_c  = 1'b0;
    retire_c  = 1'b0;
    trap_set  = 1'b0;
    cause_d   = 2'd0;
    case (state)
      FETCH: begin
        mem_req_c = 1'b1;
        if (mem.mem_ready) begin
          irwrite_c = 1'b1;
          state_d   = DECODE;
        end else if (limit_hit) begin
          trap_set = 1'b1;
          cause_d  = 2'd2;
          state_d  = HALT;
        end
      end
      DECODE: begin
        if (cls == C_ILLEGAL) begin
          trap_set = 1'b1;
          cause_d  = 2'd1;
          state_d  = HALT;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cls == C_BRANCH) begin
          pcwrite_c = 1'b1;
          pcsel_c   = taken;
          retire_c  = 1'b1;
          state_d   = FETCH;
        end else if (cls == C_LOAD || cls == C_STORE) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        mem_req_c = 1'b1;
        memrw_c   = (cls == C_STORE);
        if (mem.mem_ready) begin
          if (cls == C_STORE) begin
            pcwrite_c = 1'b1;
            retire_c  = 1'b1;
            state_d   = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (limit_hit) begin
          trap_set = 1'b1;
          cause_d  = 2'd2;
          state_d  = HALT;
        end
      end
      WB: begin
        regwen_c  = 1'b1;
        pcwrite_c = 1'b1;
        pcsel_c   = (cls == C_JAL || cls == C_JALR);
        retire_c  = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      instret    <= '0;
      trap       <= 1'b0;
      trap_cause <= 2'd0;
      to_cnt     <= '0;
    end else begin
      state <= state_d;
      if (retire_c) instret <= instret + 1'b1;
      if (trap_set) begin
        trap       <= 1'b1;
        trap_cause <= cause_d;
      end
      if (state_d != state && (state_d == FETCH || state_d == MEM)) begin
        to_cnt <= '0;
      end else if (mem_req_c && !mem.mem_ready) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // Reset gates everything combinationally so an in-flight request drops immediately.
  assign fields_en   = rst_n && (state == DECODE || state == EXEC || state == MEM || state == WB);
  assign mem.mem_req = mem_req_c & rst_n;
  assign mem.MemRW   = memrw_c & rst_n;
  assign IRWrite     = irwrite_c & rst_n;
  assign PCWrite     = pcwrite_c & rst_n;
  assign PCSel       = pcsel_c & rst_n;
  assign RegWEn      = regwen_c & rst_n;
  assign retire      = retire_c & rst_n;
  assign ImmSel      = fields_en ? imm_c : 3'd0;
  assign WBSel       = fields_en ? wb_c : 2'd0;
  assign BrUn        = fields_en & brun_c;
  assign ASel        = fields_en & asel_c;
  assign BSel        = fields_en & bsel_c;
  assign arithmetic  = fields_en & arith_c;
  assign i_type      = fields_en & itype_c;
  assign state_o     = state;

endmodule
